// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Generates VGA-style raster timing from a single clock and a pixel-advance
// strobe. The horizontal and vertical counters move only on clk edges where
// pix_en=1. Every output is registered from the counter values, so outputs
// trail the counters by exactly one clk.
//
// Optional feature: define VGA_FRAME_TICK_EN to add the frame_tick port and
// its logic. In the default build (macro undefined) neither is present.
//
// Ports:
//   clk        in   master clock
//   rst        in   asynchronous reset, active low
//   pix_en     in   pixel-advance strobe; a single-cycle pulse or held high
//   hsync      out  horizontal sync, active low
//   vsync      out  vertical sync, active low
//   video_on   out  high while the current pixel is inside the visible area
//   x          out  current pixel column (valid during blanking too)
//   y          out  current line (valid during blanking too)
//   frame_tick out  one-clk pulse at frame wrap (VGA_FRAME_TICK_EN only)
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y
`ifdef VGA_FRAME_TICK_EN
  ,
  output logic       frame_tick
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // All limits are precomputed as 10-bit values so every compare is 10 bits.
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       h_last;
  logic       v_last;

  assign h_last = (hcount == H_LAST);
  assign v_last = (vcount == V_LAST);

  // Raster counters. vcount moves only on the strobe that wraps hcount.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        hcount <= '0;
        vcount <= v_last ? '0 : vcount + 10'd1;
      end else begin
        hcount <= hcount + 10'd1;
      end
    end
  end

  // Outputs are decoded from the pre-update counter values and registered
  // on every clk, independent of pix_en, which gives the fixed 1-clk lag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b0;
      x        <= '0;
      y        <= '0;
    end else begin
      hsync    <= ~((hcount >= HS_START) && (hcount < HS_END));
      vsync    <= ~((vcount >= VS_START) && (vcount < VS_END));
      video_on <= (hcount < H_VIS) && (vcount < V_VIS);
      x        <= hcount;
      y        <= vcount;
    end
  end

`ifdef VGA_FRAME_TICK_EN
  // Asserted together with the last pixel of the frame on x/y, i.e. on the
  // clk following the strobe that wraps both counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= pix_en && h_last && v_last;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen.
// dut_m uses the default 640x480 timing for reset, hold, line and async
// reset behaviour. dut_s uses a tiny 16x10 raster so whole frames, vsync
// width and frame period can be observed within a short run.
module tb_vga_timing_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst    = 1'b0;
  logic       pix_en = 1'b0;
  logic       hs_m, vs_m, vo_m;
  logic [9:0] x_m, y_m;

  logic       rst_s  = 1'b0;
  logic       pix_s  = 1'b0;
  logic       hs_s, vs_s, vo_s;
  logic [9:0] x_s, y_s;

`ifdef VGA_FRAME_TICK_EN
  logic ft_m, ft_s;
`endif

  vga_timing_gen dut_m (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync(hs_m), .vsync(vs_m), .video_on(vo_m), .x(x_m), .y(y_m)
`ifdef VGA_FRAME_TICK_EN
    , .frame_tick(ft_m)
`endif
  );

  // 16 pixels/line (hsync 10..12), 10 lines/frame (vsync 7..8), 160 clk/frame
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_s (
    .clk(clk), .rst(rst_s), .pix_en(pix_s),
    .hsync(hs_s), .vsync(vs_s), .video_on(vo_s), .x(x_s), .y(y_s)
`ifdef VGA_FRAME_TICK_EN
    , .frame_tick(ft_s)
`endif
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Outputs settle at the posedge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int cnt = 0;      // pixels advanced on dut_m since its last reset
  int hs_low = 0;   // clk cycles with dut_m hsync low

  // One strobe followed by one idle clk: each count is shown for 2 clk.
  task automatic pulse_main();
    pix_en = 1'b1;
    tick();
    chk("x_first_clk", x_m, (cnt % 800));
    if (!hs_m) hs_low++;
    pix_en = 1'b0;
    tick();
    cnt++;
    chk("x_second_clk", x_m, (cnt % 800));
    if (!hs_m) hs_low++;
  endtask

  task automatic chk_reset_m(input string tag);
    chk({tag, "_hs"}, hs_m, 1);
    chk({tag, "_vs"}, vs_m, 1);
    chk({tag, "_vo"}, vo_m, 0);
    chk({tag, "_x"}, x_m, 0);
    chk({tag, "_y"}, y_m, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         n;     // total pixels advanced since reset
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       vo;
  } vec_t;

  vec_t vecs[10];

  // model values for the small raster
  int k, ex, ey, vs_low, ft_cnt, last_fall;
  logic prev_vs;

  initial begin
    vecs[0] = '{n:0,   x:10'd0,   y:10'd0, hs:1'b1, vs:1'b1, vo:1'b1};
    vecs[1] = '{n:639, x:10'd639, y:10'd0, hs:1'b1, vs:1'b1, vo:1'b1};
    vecs[2] = '{n:640, x:10'd640, y:10'd0, hs:1'b1, vs:1'b1, vo:1'b0};
    vecs[3] = '{n:655, x:10'd655, y:10'd0, hs:1'b1, vs:1'b1, vo:1'b0};
    vecs[4] = '{n:656, x:10'd656, y:10'd0, hs:1'b0, vs:1'b1, vo:1'b0};
    vecs[5] = '{n:751, x:10'd751, y:10'd0, hs:1'b0, vs:1'b1, vo:1'b0};
    vecs[6] = '{n:752, x:10'd752, y:10'd0, hs:1'b1, vs:1'b1, vo:1'b0};
    vecs[7] = '{n:799, x:10'd799, y:10'd0, hs:1'b1, vs:1'b1, vo:1'b0};
    vecs[8] = '{n:800, x:10'd0,   y:10'd1, hs:1'b1, vs:1'b1, vo:1'b1};
    vecs[9] = '{n:801, x:10'd1,   y:10'd1, hs:1'b1, vs:1'b1, vo:1'b1};

    // ---- reset held, pix_en toggling ----
    for (int i = 0; i < 8; i++) begin
      pix_en = i[0];
      pix_s  = ~i[0];
      tick();
      chk_reset_m("rst_held");
      chk("rst_held_s_x", x_s, 0);
      chk("rst_held_s_vo", vo_s, 0);
      chk("rst_held_s_vs", vs_s, 1);
`ifdef VGA_FRAME_TICK_EN
      chk("rst_held_ft", ft_m, 0);
`endif
    end

    // ---- hold: pix_en low for 50 clk after reset ----
    pix_en = 1'b0;
    rst    = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("hold_x", x_m, 0);
      chk("hold_y", y_m, 0);
      chk("hold_vo", vo_m, 1);
      chk("hold_hs", hs_m, 1);
    end

    // ---- one line with pix_en every 2nd clk, table checkpoints ----
    hs_low = 0;
    for (int i = 0; i < 10; i++) begin
      while (cnt < vecs[i].n) pulse_main();
      chk("vec_x", x_m, vecs[i].x);
      chk("vec_y", y_m, vecs[i].y);
      chk("vec_hs", hs_m, vecs[i].hs);
      chk("vec_vs", vs_m, vecs[i].vs);
      chk("vec_vo", vo_m, vecs[i].vo);
    end
    chk("hsync_low_clk", hs_low, 192);

    // ---- async reset mid-line at x=300, y=1 ----
    while (cnt < 1100) pulse_main();
    chk("pre_abort_x", x_m, 300);
    chk("pre_abort_y", y_m, 1);
    #3;
    rst = 1'b0;
    #1;
    chk_reset_m("async");
    pix_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_reset_m("async_held");
    end
    rst    = 1'b1;
    pix_en = 1'b0;
    cnt    = 0;
    tick();
    chk("restart_x", x_m, 0);
    chk("restart_y", y_m, 0);
    chk("restart_vo", vo_m, 1);
    pulse_main();
    chk("restart_x1", x_m, 1);

    // ---- small raster: pix_en held high for 3 frames ----
    pix_s     = 1'b1;
    rst_s     = 1'b1;
    vs_low    = 0;
    ft_cnt    = 0;
    last_fall = -1;
    prev_vs   = 1'b1;
    for (k = 0; k < 482; k++) begin
      tick();
      ex = k % 16;
      ey = (k / 16) % 10;
      chk("s_x", x_s, ex);
      chk("s_y", y_s, ey);
      chk("s_hs", hs_s, (ex >= 10 && ex < 13) ? 0 : 1);
      chk("s_vs", vs_s, (ey >= 7 && ey < 9) ? 0 : 1);
      chk("s_vo", vo_s, (ex < 8 && ey < 6) ? 1 : 0);
`ifdef VGA_FRAME_TICK_EN
      chk("s_ft", ft_s, (k % 160 == 159) ? 1 : 0);
      if (ft_s) ft_cnt++;
`endif
      if (!vs_s) vs_low++;
      if (prev_vs && !vs_s) begin
        if (last_fall >= 0) exp_q.push_back(32'(k - last_fall));
        last_fall = k;
      end
      prev_vs = vs_s;
    end
    chk("s_vs_low_clk", vs_low, 96);
    chk("s_period_count", exp_q.size(), 2);
    while (exp_q.size() > 0) chk("s_frame_period", exp_q.pop_front(), 160);
`ifdef VGA_FRAME_TICK_EN
    chk("s_ft_count", ft_cnt, 3);
`endif

    // ---- report ----
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
